ivs_ahb_regbank: RTL and testbench
==================================

Name: ivs_ahb_regbank

Overview:
- Parametrised AHB-Lite slave register bank. Successor to the fixed 8-register IVS config slave.
- Configurable count of 32-bit config registers and interrupt sources.
- Adds byte-lane writes, an ERROR response for unmapped or illegal accesses, and a W1C interrupt status block with mask and a combined irq output.
- Sits on the IVS AHB bus and drives static configuration into the IVS datapath.

Parameters:
- NUM_CFG, 8, number of 32-bit config registers (1..64).
- CFG_BASE, 12'h100, byte offset of cfg register 0; registers at CFG_BASE+4*i.
- NUM_IRQ, 8, number of interrupt sources (1..32).
- VERSION, 32'h0002_0000, value returned by the VERSION register.

Ports:
- hclk  in  1  bus clock
- hrst_n  in  1  asynchronous active-low reset
- hsel  in  1  slave select
- htrans  in  2  AHB transfer type
- hwrite  in  1  1 = write
- haddr  in  32  address; only [11:0] decoded
- hwdata  in  32  write data (data phase)
- hsize  in  3  transfer size
- hready_in  in  1  bus ready
- hready_out  out  1  slave ready
- hresp  out  2  00 OKAY, 01 ERROR
- hrdata  out  32  read data
- irq_src  in  NUM_IRQ  per-source set pulses (level-high per cycle sets bit)
- cfg_load  in  1  shadow commit strobe (used only with the optional feature)
- glb_ctrl  out  32  global control register
- sw_rst  out  1  one-cycle software reset pulse
- cfg_par  out  NUM_CFG*32  flattened config registers; reg i at [32*i+31:32*i]
- irq  out  1  OR of (IRQ_STAT & IRQ_MASK)

Behaviour:
- Clock and reset: single clock hclk. Reset hrst_n is asynchronous, active-low.
- Reset values:
  - All registers 0; hrdata 0; sw_rst 0; irq 0.
  - hready_out 1; hresp 00; FSM in IDLE.
  - Assertion mid-transfer aborts it immediately: no register is updated.
- Address phase acceptance: accepted when hsel & htrans[1] & hready_in.
  - Captured: haddr[11:0], hwrite, hsize.
  - IDLE and BUSY transfers, or hsel=0: data phase is OKAY with zero wait.
- Illegal access: hsize > 3'b010, misaligned address for the size, or unmapped offset.
- Register map:
  - 0x000 GLB_CTRL RW.
  - 0x004 SW_RST: write bit0=1 gives sw_rst high for exactly one cycle after the data phase; reads 0.
  - 0x008 IRQ_STAT W1C, NUM_IRQ LSBs.
  - 0x00C IRQ_MASK RW.
  - 0x010 VERSION RO.
  - CFG_BASE..CFG_BASE+4*(NUM_CFG-1) cfg RW.
  - Unused high bits of IRQ registers read 0, writes ignored. Writes to VERSION are ignored with OKAY.
- FSM states: IDLE, RD_WAIT, ERR1, ERR2.
- Legal write:
  - Zero wait state (hready_out=1 in data phase).
  - Byte lanes selected from hsize and haddr[1:0]: byte sets 1 lane, half sets 2, word sets 4.
  - Register updated at the clock edge ending the data phase.
- Legal read:
  - Data-phase cycle 1: state RD_WAIT, hready_out=0, hrdata loaded from the decoded mux.
  - Cycle 2: hready_out=1, hrdata valid.
  - hrdata holds its value until the next read.
- Read-after-write: a read pipelined directly after a write to the same address returns the new value.
- Error response (illegal access):
  - ERR1: hresp=01, hready_out=0.
  - ERR2: hresp=01, hready_out=1.
  - Then IDLE, or the next accepted transfer.
  - No register changes; hrdata unchanged.
- A transfer offered while hready_out=0 is not accepted, because hready_in is low.
- IRQ_STAT:
  - Bit i sets when irq_src[i]=1; clears on a write-1 to bit i.
  - Set wins over a simultaneous clear.
  - irq is registered, so it asserts 1 cycle after a status or mask change.

Optional Feature:
- Macro: IVS_REGBANK_SHADOW_EN.
- Defined:
  - Writes to cfg offsets land in shadow registers.
  - cfg_par copies all shadows on the edge where cfg_load=1.
  - Reads of cfg offsets return the shadow value.
  - If a write and cfg_load occur in the same cycle, the committed value is the new write.
- Undefined: cfg_load is ignored; writes update cfg_par directly and reads return cfg_par.

Test Plan:
- Word write 0xDEADBEEF to CFG_BASE+4, then read back -> cfg_par[63:32]=0xDEADBEEF; read has 1 wait state; hrdata=0xDEADBEEF; hresp=00.
- Byte write 0xAA to 0x002 after GLB_CTRL=0 -> glb_ctrl=0x00AA0000; half write 0x1234 to 0x000 -> 0x00AA1234.
- Read 0x200 (unmapped), then hsize=3 to 0x000 -> each gives ERROR: cycle 1 hready_out=0/hresp=01, cycle 2 hready_out=1/hresp=01; glb_ctrl unchanged.
- irq_src[3] pulse with IRQ_MASK=0x08 -> IRQ_STAT=0x08, irq=1 next cycle. Then write 0x08 to 0x008 concurrent with another irq_src[3] pulse -> bit stays 1. Clear alone -> irq=0.
- Write 0x1 to 0x004 -> sw_rst high exactly one cycle; read 0x004 returns 0.
- Reset asserted during RD_WAIT -> hready_out=1, hresp=00 immediately. With IVS_REGBANK_SHADOW_EN: write cfg0=5 -> cfg_par[31:0]=0 until cfg_load, then 5.

Source files
------------

// File: rtl/ivs_ahb_regbank_if.sv
// rtl/ivs_ahb_regbank_if.sv - AHB-Lite slave bus bundle for ivs_ahb_regbank
//
// Purpose: groups the AHB-Lite address/data/response signals of one slave port.
// Signals:
//   hsel, htrans[1:0], hwrite, haddr[31:0], hwdata[31:0], hsize[2:0], hready_in
//                                  master -> slave
//   hready_out, hresp[1:0], hrdata[31:0]
//                                  slave -> master
// Modports: master (bus side), slave (register bank side).

interface ivs_ahb_regbank_if;
  logic        hsel;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [2:0]  hsize;
  logic        hready_in;
  logic        hready_out;
  logic [1:0]  hresp;
  logic [31:0] hrdata;

  modport master (
    output hsel, htrans, hwrite, haddr, hwdata, hsize, hready_in,
    input  hready_out, hresp, hrdata
  );

  modport slave (
    input  hsel, htrans, hwrite, haddr, hwdata, hsize, hready_in,
    output hready_out, hresp, hrdata
  );
endinterface

// File: rtl/ivs_ahb_regbank.sv
// rtl/ivs_ahb_regbank.sv - parametrised AHB-Lite config and interrupt register bank
//
// Purpose: AHB-Lite slave holding GLB_CTRL, SW_RST, IRQ_STAT (W1C), IRQ_MASK,
//   VERSION and NUM_CFG config registers at CFG_BASE+4*i. Byte-lane writes with
//   zero wait states, reads with one wait state, two-cycle ERROR response for
//   oversize, misaligned or unmapped accesses.
// Ports:
//   hclk, hrst_n         clock, asynchronous active-low reset
//   ahb (slave modport)  AHB-Lite bus signals
//   irq_src[NUM_IRQ]     per-cycle interrupt set inputs
//   cfg_load             shadow commit strobe (only with IVS_REGBANK_SHADOW_EN)
//   glb_ctrl[31:0]       global control register
//   sw_rst               one-cycle software reset pulse
//   cfg_par              flattened config registers, reg i at [32*i+31:32*i]
//   irq                  registered OR of IRQ_STAT & IRQ_MASK
// Optional feature: define IVS_REGBANK_SHADOW_EN to route cfg writes through
//   shadow registers that are copied to cfg_par when cfg_load is high.

module ivs_ahb_regbank #(
  parameter int          NUM_CFG  = 8,
  parameter logic [11:0] CFG_BASE = 12'h100,
  parameter int          NUM_IRQ  = 8,
  parameter logic [31:0] VERSION  = 32'h0002_0000
) (
  input  logic                   hclk,
  input  logic                   hrst_n,
  ivs_ahb_regbank_if.slave       ahb,
  input  logic [NUM_IRQ-1:0]     irq_src,
  input  logic                   cfg_load,
  output logic [31:0]            glb_ctrl,
  output logic                   sw_rst,
  output logic [NUM_CFG*32-1:0]  cfg_par,
  output logic                   irq
);

  typedef enum logic [1:0] {IDLE = 2'd0, RD_WAIT = 2'd1, ERR1 = 2'd2, ERR2 = 2'd3} state_t;

  // Word addresses (haddr[11:2]) of the fixed registers
  localparam logic [9:0] W_GLB  = 10'd0;
  localparam logic [9:0] W_SWR  = 10'd1;
  localparam logic [9:0] W_STAT = 10'd2;
  localparam logic [9:0] W_MASK = 10'd3;
  localparam logic [9:0] W_VER  = 10'd4;
  localparam logic [9:0] CFG_W  = CFG_BASE[11:2];

  state_t               state_q, state_d;
  logic                 wr_q, wr_d;
  logic [9:0]           waddr_q, waddr_d;
  logic [3:0]           be_q, be_d;
  logic [31:0]          glb_q, glb_d;
  logic [31:0]          hrdata_q, hrdata_d;
  logic [NUM_IRQ-1:0]   stat_q, stat_d, mask_q, mask_d;
  logic                 swr_q, swr_d, irq_q, irq_d;
  logic [31:0]          cfg_q [NUM_CFG];
  logic [31:0]          cfg_d [NUM_CFG];
  logic [31:0]          cfg_rd [NUM_CFG];

  logic [9:0]  a_w;
  logic        rdy, acc, aligned, mapped, legal;
  logic [3:0]  lanes;
  logic [31:0] wmask, mask_m, rd_mux;

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [31:0] m);
    return (old_v & ~m) | (new_v & m);
  endfunction

  // Address-phase decode. Only IDLE/ERR2 drive hready_out high, so a transfer
  // can only be accepted in those states.
  assign a_w    = ahb.haddr[11:2];
  assign rdy    = (state_q == IDLE) || (state_q == ERR2);
  assign acc    = ahb.hsel && ahb.htrans[1] && ahb.hready_in && rdy;
  assign mapped = (a_w <= W_VER) ||
                  ((a_w >= CFG_W) && ({1'b0, a_w} < ({1'b0, CFG_W} + 11'(NUM_CFG))));
  assign legal  = aligned && mapped;

  always_comb begin
    aligned = 1'b1;
    lanes   = 4'b0000;
    case (ahb.hsize)
      3'b000:  lanes = 4'b0001 << ahb.haddr[1:0];
      3'b001:  begin aligned = ~ahb.haddr[0]; lanes = ahb.haddr[1] ? 4'b1100 : 4'b0011; end
      3'b010:  begin aligned = (ahb.haddr[1:0] == 2'b00); lanes = 4'b1111; end
      default: aligned = 1'b0;  // wider than a word
    endcase
  end

  // Bus FSM
  always_comb begin
    state_d = IDLE;
    wr_d    = 1'b0;
    waddr_d = waddr_q;
    be_d    = be_q;
    if (state_q == ERR1) state_d = ERR2;
    if (acc) begin
      if (!legal) begin
        state_d = ERR1;
      end else begin
        waddr_d = a_w;
        be_d    = lanes;
        wr_d    = ahb.hwrite;
        if (!ahb.hwrite) state_d = RD_WAIT;
      end
    end
  end

  assign wmask = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};

`ifdef IVS_REGBANK_SHADOW_EN
  logic [31:0] shd_q [NUM_CFG];
  logic [31:0] shd_d [NUM_CFG];

  // The commit copies shd_d so a write landing with cfg_load is committed too.
  always_comb begin
    for (int i = 0; i < NUM_CFG; i++) begin
      shd_d[i] = shd_q[i];
      if (wr_q && (waddr_q == CFG_W + 10'(i))) shd_d[i] = merge(shd_q[i], ahb.hwdata, wmask);
      cfg_d[i]  = cfg_load ? shd_d[i] : cfg_q[i];
      cfg_rd[i] = shd_q[i];
    end
  end

  always_ff @(posedge hclk or negedge hrst_n) begin
    if (!hrst_n) begin
      for (int i = 0; i < NUM_CFG; i++) shd_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CFG; i++) shd_q[i] <= shd_d[i];
    end
  end

  logic unused_ok;
  assign unused_ok = ^{ahb.haddr[31:12], ahb.htrans[0]};
`else
  always_comb begin
    for (int i = 0; i < NUM_CFG; i++) begin
      cfg_d[i] = cfg_q[i];
      if (wr_q && (waddr_q == CFG_W + 10'(i))) cfg_d[i] = merge(cfg_q[i], ahb.hwdata, wmask);
      cfg_rd[i] = cfg_q[i];
    end
  end

  logic unused_ok;
  assign unused_ok = ^{ahb.haddr[31:12], ahb.htrans[0], cfg_load};
`endif

  // Register writes happen at the edge ending the zero-wait data phase.
  always_comb begin
    glb_d  = glb_q;
    mask_d = mask_q;
    stat_d = stat_q;
    mask_m = merge(32'(mask_q), ahb.hwdata, wmask);
    if (wr_q && (waddr_q == W_GLB))  glb_d  = merge(glb_q, ahb.hwdata, wmask);
    if (wr_q && (waddr_q == W_MASK)) mask_d = mask_m[NUM_IRQ-1:0];
    if (wr_q && (waddr_q == W_STAT)) stat_d = stat_q & ~(ahb.hwdata[NUM_IRQ-1:0] & wmask[NUM_IRQ-1:0]);
    stat_d = stat_d | irq_src;  // set wins over a same-cycle clear
    swr_d  = wr_q && (waddr_q == W_SWR) && be_q[0] && ahb.hwdata[0];
    irq_d  = |(stat_q & mask_q);
  end

  // Read mux, sampled into hrdata at the end of RD_WAIT
  always_comb begin
    rd_mux = 32'h0;
    for (int i = 0; i < NUM_CFG; i++) begin
      if (waddr_q == CFG_W + 10'(i)) rd_mux = cfg_rd[i];
    end
    case (waddr_q)
      W_GLB:   rd_mux = glb_q;
      W_SWR:   rd_mux = 32'h0;
      W_STAT:  rd_mux = 32'(stat_q);
      W_MASK:  rd_mux = 32'(mask_q);
      W_VER:   rd_mux = VERSION;
      default: ;
    endcase
    hrdata_d = (state_q == RD_WAIT) ? rd_mux : hrdata_q;
  end

  always_ff @(posedge hclk or negedge hrst_n) begin
    if (!hrst_n) begin
      state_q  <= IDLE;
      wr_q     <= 1'b0;
      waddr_q  <= '0;
      be_q     <= '0;
      glb_q    <= '0;
      hrdata_q <= '0;
      stat_q   <= '0;
      mask_q   <= '0;
      swr_q    <= 1'b0;
      irq_q    <= 1'b0;
      for (int i = 0; i < NUM_CFG; i++) cfg_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      waddr_q  <= waddr_d;
      be_q     <= be_d;
      glb_q    <= glb_d;
      hrdata_q <= hrdata_d;
      stat_q   <= stat_d;
      mask_q   <= mask_d;
      swr_q    <= swr_d;
      irq_q    <= irq_d;
      for (int i = 0; i < NUM_CFG; i++) cfg_q[i] <= cfg_d[i];
    end
  end

  assign ahb.hready_out = rdy;
  assign ahb.hresp      = ((state_q == ERR1) || (state_q == ERR2)) ? 2'b01 : 2'b00;
  assign ahb.hrdata     = hrdata_q;
  assign glb_ctrl       = glb_q;
  assign sw_rst         = swr_q;
  assign irq            = irq_q;

  for (genvar g = 0; g < NUM_CFG; g++) begin : g_cfg
    assign cfg_par[32*g +: 32] = cfg_q[g];
  end

endmodule

// File: tb/tb_ivs_ahb_regbank.sv
// tb/tb_ivs_ahb_regbank.sv - directed self-checking bench for ivs_ahb_regbank

module tb_ivs_ahb_regbank;

  logic         hclk = 1'b0;
  logic         hrst_n = 1'b0;
  logic [7:0]   irq_src = '0;
  logic         cfg_load = 1'b0;
  logic [31:0]  glb_ctrl;
  logic         sw_rst;
  logic [255:0] cfg_par;
  logic         irq;

  int checks = 0;
  int errors = 0;

  logic [31:0] rd_v;
  int          wt_v;
  logic [1:0]  r0_v, r1_v;

  ivs_ahb_regbank_if bus ();
  assign bus.hready_in = bus.hready_out;

  ivs_ahb_regbank dut (
    .hclk     (hclk),
    .hrst_n   (hrst_n),
    .ahb      (bus),
    .irq_src  (irq_src),
    .cfg_load (cfg_load),
    .glb_ctrl (glb_ctrl),
    .sw_rst   (sw_rst),
    .cfg_par  (cfg_par),
    .irq      (irq)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic bus_idle();
    bus.hsel   = 1'b0;
    bus.htrans = 2'b00;
    bus.hwrite = 1'b0;
    bus.haddr  = '0;
    bus.hsize  = 3'b010;
  endtask

  task automatic addr_phase(input logic wr, input logic [31:0] addr, input logic [2:0] size);
    bus.hsel   = 1'b1;
    bus.htrans = 2'b10;
    bus.hwrite = wr;
    bus.haddr  = addr;
    bus.hsize  = size;
  endtask

  // Single non-pipelined transfer; the wait-state loop is bounded.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata);
    addr_phase(wr, addr, size);
    tick();
    bus_idle();
    bus.hwdata = wdata;
    wt_v = 0;
    r0_v = bus.hresp;
    while (bus.hready_out !== 1'b1 && wt_v < 8) begin
      tick();
      wt_v++;
    end
    r1_v = bus.hresp;
    rd_v = bus.hrdata;
    tick();
  endtask

  task automatic commit();
`ifdef IVS_REGBANK_SHADOW_EN
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
`endif
  endtask

  initial begin
    bus_idle();
    bus.hwdata = '0;
    repeat (2) @(posedge hclk);
    #1;
    chk("rst_hready", 64'(bus.hready_out), 64'd1);
    chk("rst_hresp", 64'(bus.hresp), 64'd0);
    chk("rst_hrdata", 64'(bus.hrdata), 64'd0);
    chk("rst_glb", 64'(glb_ctrl), 64'd0);
    chk("rst_swrst", 64'(sw_rst), 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);
    chk("rst_cfg_lo", cfg_par[63:0], 64'd0);
    hrst_n = 1'b1;
    tick();

    // Word write/read of cfg1
    xfer(1'b1, 32'h104, 3'b010, 32'hDEADBEEF);
    chk("cfg1_wr_waits", 64'(wt_v), 64'd0);
    chk("cfg1_wr_resp", 64'(r1_v), 64'd0);
    commit();
    chk("cfg1_par", 64'(cfg_par[63:32]), 64'hDEADBEEF);
    xfer(1'b0, 32'h104, 3'b010, 32'h0);
    chk("cfg1_rd_waits", 64'(wt_v), 64'd1);
    chk("cfg1_rd_data", 64'(rd_v), 64'hDEADBEEF);
    chk("cfg1_rd_resp", 64'(r1_v), 64'd0);

    // Byte lanes on GLB_CTRL; replicated data exposes wrong lane selection
    xfer(1'b1, 32'h000, 3'b010, 32'h0);
    xfer(1'b1, 32'h002, 3'b000, 32'hAAAAAAAA);
    chk("glb_byte2", 64'(glb_ctrl), 64'h00AA0000);
    xfer(1'b1, 32'h000, 3'b001, 32'h12341234);
    chk("glb_half0", 64'(glb_ctrl), 64'h00AA1234);

    // Error responses: unmapped, oversize, misaligned, one past last cfg
    xfer(1'b0, 32'h200, 3'b010, 32'h0);
    chk("unmap_c1_resp", 64'(r0_v), 64'd1);
    chk("unmap_waits", 64'(wt_v), 64'd1);
    chk("unmap_c2_resp", 64'(r1_v), 64'd1);
    chk("unmap_hrdata_held", 64'(rd_v), 64'hDEADBEEF);
    xfer(1'b1, 32'h000, 3'b011, 32'hFFFFFFFF);
    chk("size3_c1_resp", 64'(r0_v), 64'd1);
    chk("size3_waits", 64'(wt_v), 64'd1);
    chk("size3_c2_resp", 64'(r1_v), 64'd1);
    chk("size3_glb_kept", 64'(glb_ctrl), 64'h00AA1234);
    xfer(1'b1, 32'h002, 3'b010, 32'hFFFFFFFF);
    chk("misalign_resp", 64'(r1_v), 64'd1);
    chk("misalign_glb_kept", 64'(glb_ctrl), 64'h00AA1234);
    xfer(1'b1, 32'h120, 3'b010, 32'h1);
    chk("past_cfg_resp", 64'(r1_v), 64'd1);
    xfer(1'b1, 32'h11C, 3'b010, 32'hCAFEF00D);
    chk("last_cfg_resp", 64'(r1_v), 64'd0);
    commit();
    chk("last_cfg_par", 64'(cfg_par[255:224]), 64'hCAFEF00D);

    // VERSION is read-only; IRQ_MASK keeps only NUM_IRQ bits
    xfer(1'b1, 32'h010, 3'b010, 32'h12345678);
    chk("ver_wr_resp", 64'(r1_v), 64'd0);
    xfer(1'b0, 32'h010, 3'b010, 32'h0);
    chk("ver_rd", 64'(rd_v), 64'h00020000);
    xfer(1'b1, 32'h00C, 3'b010, 32'hFFFFFFFF);
    xfer(1'b0, 32'h00C, 3'b010, 32'h0);
    chk("mask_hi_zero", 64'(rd_v), 64'h000000FF);

    // Interrupt set, registered irq, set-wins, clear
    xfer(1'b1, 32'h00C, 3'b010, 32'h00000008);
    irq_src = 8'h08;
    tick();
    irq_src = 8'h00;
    chk("irq_lag", 64'(irq), 64'd0);
    tick();
    chk("irq_set", 64'(irq), 64'd1);
    xfer(1'b0, 32'h008, 3'b010, 32'h0);
    chk("stat_set", 64'(rd_v), 64'h08);
    addr_phase(1'b1, 32'h008, 3'b010);
    tick();
    bus_idle();
    bus.hwdata = 32'h08;
    irq_src = 8'h08;
    tick();
    irq_src = 8'h00;
    xfer(1'b0, 32'h008, 3'b010, 32'h0);
    chk("stat_set_wins", 64'(rd_v), 64'h08);
    xfer(1'b1, 32'h008, 3'b010, 32'h08);
    chk("irq_before_clr", 64'(irq), 64'd1);
    tick();
    chk("irq_clr", 64'(irq), 64'd0);
    xfer(1'b0, 32'h008, 3'b010, 32'h0);
    chk("stat_clr", 64'(rd_v), 64'h00);

    // Software reset pulse
    addr_phase(1'b1, 32'h004, 3'b010);
    tick();
    bus_idle();
    bus.hwdata = 32'h1;
    chk("swrst_dphase", 64'(sw_rst), 64'd0);
    tick();
    chk("swrst_pulse", 64'(sw_rst), 64'd1);
    tick();
    chk("swrst_end", 64'(sw_rst), 64'd0);
    xfer(1'b0, 32'h004, 3'b010, 32'h0);
    chk("swrst_rd", 64'(rd_v), 64'h0);

    // Read pipelined directly after a write to the same address
    addr_phase(1'b1, 32'h108, 3'b010);
    tick();
    bus.hwdata = 32'h55AA55AA;
    addr_phase(1'b0, 32'h108, 3'b010);
    chk("raw_wr_ready", 64'(bus.hready_out), 64'd1);
    tick();
    bus_idle();
    chk("raw_rd_wait", 64'(bus.hready_out), 64'd0);
    tick();
    chk("raw_rd_ready", 64'(bus.hready_out), 64'd1);
    chk("raw_rd_data", 64'(bus.hrdata), 64'h55AA55AA);
    tick();

`ifdef IVS_REGBANK_SHADOW_EN
    xfer(1'b1, 32'h100, 3'b010, 32'h5);
    chk("shd_hold", 64'(cfg_par[31:0]), 64'h0);
    xfer(1'b0, 32'h100, 3'b010, 32'h0);
    chk("shd_rd", 64'(rd_v), 64'h5);
    commit();
    chk("shd_commit", 64'(cfg_par[31:0]), 64'h5);
`endif

    // Asynchronous reset during RD_WAIT
    addr_phase(1'b0, 32'h000, 3'b010);
    tick();
    bus_idle();
    chk("rdwait_before_rst", 64'(bus.hready_out), 64'd0);
    hrst_n = 1'b0;
    #1;
    chk("rst_mid_hready", 64'(bus.hready_out), 64'd1);
    chk("rst_mid_hresp", 64'(bus.hresp), 64'd0);
    chk("rst_mid_glb", 64'(glb_ctrl), 64'd0);
    tick();
    hrst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
